// File: rtl/fp_mul_round.sv
// fp_mul_round: two-stage normalize / round / pack for the binary32 multiplier.
// Define FP_ROUND_MODES_EN for all five rounding modes; default is RNE only.
module fp_mul_round (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [9:0]  in_exp,
  input  logic [47:0] in_mant,
  input  logic [1:0]  in_class,
  input  logic [2:0]  in_frm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        overflow,
  output logic        underflow,
  output logic        inexact
);

  logic        s1_valid;
  logic        s1_sign;
  logic [9:0]  s1_exp;
  logic [23:0] s1_sig;
  logic        s1_g;
  logic        s1_r;
  logic        s1_s;
  logic [1:0]  s1_cls;
`ifdef FP_ROUND_MODES_EN
  logic [2:0]  s1_frm;
`else
  logic        unused_frm;
  assign unused_frm = ^in_frm;
`endif

  logic s1_adv;
  logic s2_adv;

  assign s2_adv   = !out_valid | out_ready;
  assign s1_adv   = !s1_valid | s2_adv;
  assign in_ready = s1_adv;

  logic [5:0]  lzc;
  logic [11:0] e_in;
  logic [11:0] e_m1;
  logic [11:0] e_n;
  logic [11:0] rsh_full;
  logic [5:0]  lsh;
  logic [4:0]  rsh;
  logic [46:0] m_n;
  logic        st_n;
  logic [9:0]  e_fin;

  always_comb begin
    lzc = 6'd47;
    for (int i = 0; i < 47; i++)
      if (in_mant[i]) lzc = 6'(46 - i);
  end

  always_comb begin
    e_in     = {{2{in_exp[9]}}, in_exp};
    e_m1     = e_in - 12'd1;
    e_n      = e_in;
    m_n      = in_mant[46:0];
    st_n     = 1'b0;
    lsh      = '0;
    rsh      = '0;
    rsh_full = '0;
    if (in_mant[47]) begin
      m_n  = in_mant[47:1];
      st_n = in_mant[0];
      e_n  = e_in + 12'd1;
    end else if (!in_mant[46] && !e_m1[11] && e_m1 != '0) begin
      lsh = (e_m1 > {6'd0, lzc}) ? lzc : e_m1[5:0];
      m_n = in_mant[46:0] << lsh;
      e_n = e_in - {6'd0, lsh};
    end
    if (e_n[11] || e_n == '0) begin
      rsh_full = 12'd1 - e_n;
      rsh      = (rsh_full > 12'd26) ? 5'd26 : rsh_full[4:0];
      st_n     = st_n | (|(m_n & ((47'd1 << rsh) - 47'd1)));
      m_n      = m_n >> rsh;
      e_n      = '0;
    end
    // no hidden bit left means the significand already sits on the subnormal grid
    if (!m_n[46])
      e_fin = '0;
    else if (e_n > 12'd511)
      e_fin = 10'd511;
    else
      e_fin = e_n[9:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_exp   <= '0;
      s1_sig   <= '0;
      s1_g     <= 1'b0;
      s1_r     <= 1'b0;
      s1_s     <= 1'b0;
      s1_cls   <= '0;
`ifdef FP_ROUND_MODES_EN
      s1_frm   <= '0;
`endif
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sign <= in_sign;
        s1_exp  <= e_fin;
        s1_sig  <= m_n[46:23];
        s1_g    <= m_n[22];
        s1_r    <= m_n[21];
        s1_s    <= (|m_n[20:0]) | st_n;
        s1_cls  <= in_class;
`ifdef FP_ROUND_MODES_EN
        s1_frm  <= in_frm;
`endif
      end
    end
  end

  logic        grs;
  logic        inc;
  logic        tiny;
  logic        ovf_inf;
  logic [24:0] sum;
  logic [10:0] e_r;
  logic [22:0] frac;
  logic [31:0] res_d;
  logic        ovf_d;
  logic        unf_d;
  logic        inx_d;

  always_comb begin
    grs     = s1_g | s1_r | s1_s;
    tiny    = (s1_exp == '0);
    inc     = s1_g & (s1_r | s1_s | s1_sig[0]);
    ovf_inf = 1'b1;
`ifdef FP_ROUND_MODES_EN
    unique case (s1_frm)
      3'b001: begin
        inc     = 1'b0;
        ovf_inf = 1'b0;
      end
      3'b010: begin
        inc     = s1_sign & grs;
        ovf_inf = s1_sign;
      end
      3'b011: begin
        inc     = !s1_sign & grs;
        ovf_inf = !s1_sign;
      end
      3'b100: inc = s1_g;
      default: ;
    endcase
`endif
    sum  = {1'b0, s1_sig} + {24'd0, inc};
    e_r  = {1'b0, s1_exp};
    frac = sum[22:0];
    if (sum[24])
      e_r = e_r + 11'd1;
    else if (tiny && sum[23])
      e_r = 11'd1;
    res_d = {s1_sign, e_r[7:0], frac};
    ovf_d = 1'b0;
    unf_d = tiny & grs;
    inx_d = grs;
    if (e_r >= 11'd255) begin
      res_d = ovf_inf ? {s1_sign, 8'hFF, 23'd0} : {s1_sign, 31'h7F7FFFFF};
      ovf_d = 1'b1;
      inx_d = 1'b1;
    end
    case (s1_cls)
      2'b01: res_d = {s1_sign, 31'd0};
      2'b10: res_d = {s1_sign, 8'hFF, 23'd0};
      2'b11: res_d = 32'h7FC00000;
      default: ;
    endcase
    if (s1_cls != 2'b00) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
      inx_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      inexact   <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        result    <= res_d;
        overflow  <= ovf_d;
        underflow <= unf_d;
        inexact   <= inx_d;
      end
    end
  end

endmodule

// File: tb/tb_fp_mul_round.sv
// tb_fp_mul_round: directed and randomized checks of fp_mul_round against
// an exact integer rounding model with a scoreboard queue.
module tb_fp_mul_round;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [9:0]  in_exp;
  logic [47:0] in_mant;
  logic [1:0]  in_class;
  logic [2:0]  in_frm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        overflow;
  logic        underflow;
  logic        inexact;

  fp_mul_round dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (in_sign),
    .in_exp    (in_exp),
    .in_mant   (in_mant),
    .in_class  (in_class),
    .in_frm    (in_frm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .overflow  (overflow),
    .underflow (underflow),
    .inexact   (inexact)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [34:0] exp;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   checks = 0;
  int   errors = 0;
  int   outs   = 0;
  bit   acc;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Exact model: scale P onto the result grid, round on the remainder.
  function automatic logic [34:0] ref_mul(input logic s, input int e,
                                          input logic [47:0] p,
                                          input logic [1:0] c,
                                          input logic [2:0] f);
    int           msb, be, k;
    logic [127:0] one, q, rem, half;
    logic         inx, up, tiny;
    logic [2:0]   m;
    logic [31:0]  w;
    if (c == 2'b11) return {32'h7FC00000, 3'b000};
    if (c == 2'b01) return {s, 31'd0, 3'b000};
    if (c == 2'b10) return {s, 8'hFF, 23'd0, 3'b000};
    if (p == '0) return {s, 31'd0, 3'b000};
    m = f;
`ifndef FP_ROUND_MODES_EN
    m = 3'd0;
`endif
    msb = 0;
    for (int i = 0; i < 48; i++)
      if (p[i]) msb = i;
    be   = e + msb - 46;
    tiny = (be <= 0);
    k    = tiny ? 24 - e : msb - 23;
    one  = 128'd1;
    if (k <= 0) begin
      q    = {80'd0, p} << (-k);
      rem  = '0;
      half = '0;
    end else if (k > 100) begin
      q    = '0;
      rem  = {80'd0, p};
      half = one << 100;
    end else begin
      q    = {80'd0, p} >> k;
      rem  = {80'd0, p} & ((one << k) - one);
      half = one << (k - 1);
    end
    inx = (rem != '0);
    case (m)
      3'd1:    up = 1'b0;
      3'd2:    up = s & inx;
      3'd3:    up = ~s & inx;
      3'd4:    up = inx && (rem >= half);
      default: up = inx && ((rem > half) || (rem == half && q[0]));
    endcase
    q = q + {127'd0, up};
    if (!tiny && q == (one << 24)) begin
      q  = one << 23;
      be = be + 1;
    end
    if (be >= 255) begin
      if (m == 3'd1 || (m == 3'd2 && !s) || (m == 3'd3 && s))
        w = {s, 31'h7F7FFFFF};
      else
        w = {s, 8'hFF, 23'd0};
      return {w, 3'b101};
    end
    if (tiny) w = {s, q[30:0]};
    else      w = {s, 8'(be), q[22:0]};
    return {w, 1'b0, tiny & inx, inx};
  endfunction

  task automatic drive(input string tag, input logic s, input int e,
                       input logic [47:0] p, input logic [1:0] c,
                       input logic [2:0] f, input logic [34:0] x);
    in_valid = 1'b1;
    in_sign  = s;
    in_exp   = 10'(e);
    in_mant  = p;
    in_class = c;
    in_frm   = f;
    cur.tag  = tag;
    cur.exp  = x;
  endtask

  // Inputs are set just after a negedge; evaluate handshakes, cross posedge.
  task automatic tick();
    exp_t h;
    #1;
    acc = in_valid && in_ready;
    if (out_valid && out_ready) begin
      outs++;
      if (exp_q.size() == 0) begin
        check("spurious", 64'(out_valid), 64'(0));
      end else begin
        h = exp_q.pop_front();
        check(h.tag, 64'({result, overflow, underflow, inexact}), 64'(h.exp));
      end
    end
    if (acc) exp_q.push_back(cur);
    @(negedge clk);
  endtask

  task automatic send(input string tag, input logic s, input int e,
                      input logic [47:0] p, input logic [1:0] c,
                      input logic [2:0] f, input logic [34:0] x);
    int n;
    drive(tag, s, e, p, c, f, x);
    n = 0;
    do begin
      tick();
      n++;
    end while (!acc && n < 50);
    if (!acc) check({tag, "_timeout"}, 64'(acc), 64'(1));
  endtask

  task automatic flush();
    int n;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    check("flush", 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          lat, n, outs0;
    logic        s;
    int          e;
    logic [23:0] ma, mb;
    logic [47:0] p;
    logic [1:0]  c;
    logic [2:0]  f;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_sign   = 1'b0;
    in_exp    = '0;
    in_mant   = '0;
    in_class  = '0;
    in_frm    = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_state",
          64'({out_valid, result, overflow, underflow, inexact}), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(1));
    @(negedge clk);
    rst = 1'b0;

    drive("mul_1p5", 1'b0, 127, 48'h900000000000, 2'b00, 3'd0,
          {32'h40100000, 3'b000});
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      tick();
      lat++;
    end
    check("latency", 64'(lat), 64'(2));
    flush();

    send("tie_rne", 1'b0, 127, 48'h400000C00000, 2'b00, 3'd0,
         {32'h3F800002, 3'b001});
    send("ovf_rne", 1'b0, 260, 48'h400000000000, 2'b00, 3'd0,
         {32'h7F800000, 3'b101});
`ifdef FP_ROUND_MODES_EN
    send("tie_rtz", 1'b0, 127, 48'h400000C00000, 2'b00, 3'd1,
         {32'h3F800001, 3'b001});
    send("ovf_rtz", 1'b0, 260, 48'h400000000000, 2'b00, 3'd1,
         {32'h7F7FFFFF, 3'b101});
`endif
    send("sub_exact", 1'b0, -10, 48'h400000000000, 2'b00, 3'd0,
         {32'h00001000, 3'b000});
    send("sub_flush", 1'b0, -30, 48'h400000000000, 2'b00, 3'd0,
         {32'h00000000, 3'b011});
    send("nan", 1'b0, 127, 48'h400000C00000, 2'b11, 3'd0,
         {32'h7FC00000, 3'b000});
    send("neg_zero", 1'b1, 127, 48'h400000C00000, 2'b01, 3'd0,
         {32'h80000000, 3'b000});
    send("neg_inf", 1'b1, 300, 48'h400000C00000, 2'b10, 3'd0,
         {32'hFF800000, 3'b000});
    flush();

    out_ready = 1'b0;
    n = 0;
    for (int i = 0; i < 20 && n < 2; i++) begin
      if (n == 0)
        drive("bp0", 1'b0, 127, 48'h400000000000, 2'b00, 3'd0,
              {32'h3F800000, 3'b000});
      else
        drive("bp1", 1'b0, 127, 48'h600000000000, 2'b00, 3'd0,
              {32'h3FC00000, 3'b000});
      tick();
      if (acc) n++;
    end
    drive("bp2", 1'b0, 128, 48'h900000000000, 2'b00, 3'd0,
          {32'h40900000, 3'b000});
    #1;
    check("bp_in_ready", 64'(in_ready), 64'(0));
    repeat (3) tick();
    check("bp_out_valid", 64'(out_valid), 64'(1));
    check("bp_hold", 64'(result), 64'(32'h3F800000));
    check("bp_in_ready2", 64'(in_ready), 64'(0));
    out_ready = 1'b1;
    outs0 = outs;
    for (int i = 0; i < 20 && (in_valid || exp_q.size() != 0); i++) begin
      tick();
      if (acc) in_valid = 1'b0;
    end
    check("bp_drain_count", 64'(outs - outs0), 64'(3));

    send("rst_a", 1'b0, 127, 48'h400000000000, 2'b00, 3'd0,
         {32'h3F800000, 3'b000});
    send("rst_b", 1'b1, 127, 48'h600000000000, 2'b00, 3'd0,
         {32'hBFC00000, 3'b000});
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_flush", 64'(out_valid), 64'(0));
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    outs0 = outs;
    repeat (6) tick();
    check("rst_no_emit", 64'(outs - outs0), 64'(0));

    for (int i = 0; i < 400; i++) begin
      s  = 1'($urandom_range(0, 1));
      ma = {($urandom_range(0, 7) != 0), 23'($urandom)};
      mb = {($urandom_range(0, 7) != 0), 23'($urandom)};
      p  = 48'(ma) * 48'(mb);
      e  = int'($urandom_range(0, 360)) - 60;
      c  = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      f  = 3'($urandom_range(0, 4));
      if ($urandom_range(0, 4) == 0) begin
        in_valid  = 1'b0;
        out_ready = ($urandom_range(0, 3) != 0);
        tick();
      end
      drive($sformatf("rnd%0d", i), s, e, p, c, f, ref_mul(s, e, p, c, f));
      n = 0;
      do begin
        out_ready = ($urandom_range(0, 3) != 0);
        tick();
        n++;
      end while (!acc && n < 50);
      if (!acc) check("rnd_timeout", 64'(acc), 64'(1));
    end
    flush();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
